// File: rtl/data_mem_rv32i_if.sv
// Load/store bus between the RV32I memory stage and the byte-lane data memory.
// The master drives the request fields; the memory returns the extended load result.
interface data_mem_rv32i_if #(
    parameter int ADDR_W = 9
);
    logic              we;
    logic              re;
    logic [2:0]        width_sel;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;

    modport master (
        output we, re, width_sel, addr, wdata,
        input  rdata
    );

    modport slave (
        input  we, re, width_sel, addr, wdata,
        output rdata
    );
endinterface

// File: rtl/data_mem_rv32i.sv
// Byte-addressable RV32I data memory: four little-endian byte-lane banks with
// synchronous read/write, SB/SH/SW stores and LB/LH/LW/LBU/LHU loads (1-cycle latency).
module data_mem_rv32i #(
    parameter int ADDR_W          = 9,
    parameter bit MISALIGNED_ZERO = 1'b1
) (
    input logic              clk,
    input logic              rst,
    data_mem_rv32i_if.slave  bus
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);

    typedef enum logic [2:0] {
        W_B  = 3'b000,
        W_H  = 3'b001,
        W_W  = 3'b010,
        W_BU = 3'b011,
        W_HU = 3'b100
    } width_e;

    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        lane;
    logic              misaligned;

    assign word_idx = bus.addr[ADDR_W-1:2];
    assign lane     = bus.addr[1:0];

    // With aligning-down, lane selection already ignores the offending low bits,
    // so misalignment only matters when those accesses must be suppressed.
    always_comb begin
        misaligned = 1'b0;
        case (width_e'(bus.width_sel))
            W_H, W_HU: misaligned = lane[0];
            W_W:       misaligned = (lane != 2'b00);
            default:   misaligned = 1'b0;
        endcase
    end

    // ---------------- store lane steering ----------------
    logic [3:0] lane_we;
    logic [7:0] lane_wd [4];

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        lane_we = 4'b0000;
        for (int k = 0; k < 4; k++) lane_wd[k] = bus.wdata[8*k +: 8];
        if (bus.we && !rst && !(MISALIGNED_ZERO && misaligned)) begin
            case (width_e'(bus.width_sel))
                W_B: begin
                    lane_we[lane] = 1'b1;
                    for (int k = 0; k < 4; k++) lane_wd[k] = bus.wdata[7:0];
                end
                W_H: begin
                    lane_we = lane[1] ? 4'b1100 : 4'b0011;
                    for (int k = 0; k < 4; k++) lane_wd[k] = bus.wdata[8*(k%2) +: 8];
                end
                W_W:     lane_we = 4'b1111;
                default: lane_we = 4'b0000;
            endcase
        end
    end

    // ---------------- lane banks ----------------
    logic [7:0] lane_q [4];

    for (genvar k = 0; k < 4; k++) begin : g_lane
        // NOTE: memory arrays are never reset; they start at zero via the
        // declaration initialiser, which block RAMs honour as power-up contents.
        logic [7:0] mem [DEPTH] = '{default: 8'h00};
        logic [7:0] q;

        // NOTE: non-blocking assignments give read-first behaviour on a same-edge write.
        always_ff @(posedge clk) begin
            if (lane_we[k]) mem[word_idx] <= lane_wd[k];
            if (bus.re && !rst) q <= mem[word_idx];
        end

        assign lane_q[k] = q;
    end

    // ---------------- registered load controls ----------------
    logic       valid_r;
    logic [2:0] width_r;
    logic [1:0] lane_r;
    logic       mis_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            width_r <= 3'b000;
            lane_r  <= 2'b00;
            mis_r   <= 1'b0;
        end else if (bus.re) begin
            valid_r <= 1'b1;
            width_r <= bus.width_sel;
            lane_r  <= lane;
            mis_r   <= MISALIGNED_ZERO && misaligned;
        end
    end

    // ---------------- load formatting ----------------
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte  = lane_q[lane_r];
        sel_half  = lane_r[1] ? {lane_q[3], lane_q[2]} : {lane_q[1], lane_q[0]};
        bus.rdata = 32'h0000_0000;
        if (valid_r && !mis_r) begin
            case (width_e'(width_r))
                W_B:     bus.rdata = {{24{sel_byte[7]}}, sel_byte};
                W_BU:    bus.rdata = {24'h000000, sel_byte};
                W_H:     bus.rdata = {{16{sel_half[15]}}, sel_half};
                W_HU:    bus.rdata = {16'h0000, sel_half};
                W_W:     bus.rdata = {lane_q[3], lane_q[2], lane_q[1], lane_q[0]};
                default: bus.rdata = 32'h0000_0000;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_rv32i.sv
// Directed self-checking bench for data_mem_rv32i: zero init, extension,
// misalignment, partial stores, read-first collision and reset behaviour.
module tb_data_mem_rv32i;
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b011;
    localparam logic [2:0] LHU = 3'b100;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    data_mem_rv32i_if #(.ADDR_W(9)) bus ();

    data_mem_rv32i #(
        .ADDR_W          (9),
        .MISALIGNED_ZERO (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One access: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic cycle(input logic w, input logic r, input logic [2:0] ws,
                         input logic [8:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we        = w;
        bus.re        = r;
        bus.width_sel = ws;
        bus.addr      = a;
        bus.wdata     = d;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        bus.re = 1'b0;
    endtask

    task automatic store(input logic [2:0] ws, input logic [8:0] a, input logic [31:0] d);
        cycle(1'b1, 1'b0, ws, a, d);
    endtask

    task automatic load(input logic [2:0] ws, input logic [8:0] a,
                        input logic [31:0] exp, input string tag);
        cycle(1'b0, 1'b1, ws, a, 32'h0);
        check(tag, bus.rdata, exp);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.we        = 1'b0;
        bus.re        = 1'b0;
        bus.width_sel = 3'b000;
        bus.addr      = '0;
        bus.wdata     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", bus.rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Power-up contents are zero.
        for (int a = 0; a <= 24; a++) load(LB, 9'(a), 32'h0, "t1_lb_zero");

        // Word stores then word loads, issued back to back.
        for (int a = 0; a <= 16; a += 4) store(LW, 9'(a), 32'hA5A5_0000 + 32'(a));
        for (int a = 0; a <= 16; a += 4) load(LW, 9'(a), 32'hA5A5_0000 + 32'(a), "t2_lw");

        // Extension at 0x00C = 0xA5A5000C.
        load(LB,  9'h00C, 32'h0000_000C, "t3_lb_0c");
        load(LB,  9'h00E, 32'hFFFF_FFA5, "t3_lb_0e");
        load(LBU, 9'h00E, 32'h0000_00A5, "t3_lbu_0e");
        load(LH,  9'h00C, 32'h0000_000C, "t3_lh_0c");
        load(LH,  9'h00E, 32'hFFFF_A5A5, "t3_lh_0e");
        load(LHU, 9'h00E, 32'h0000_A5A5, "t3_lhu_0e");
        load(LBU, 9'h00F, 32'h0000_00A5, "t3_lbu_0f");

        // Misaligned accesses are zeroed / dropped.
        load(LH,  9'h00D, 32'h0, "t4_lh_mis");
        load(LHU, 9'h00F, 32'h0, "t4_lhu_mis");
        load(LW,  9'h002, 32'h0, "t4_lw_mis");
        store(LH, 9'h00D, 32'h0000_BEEF);
        load(LW,  9'h00C, 32'hA5A5_000C, "t4_sh_dropped");
        store(LW, 9'h009, 32'hFFFF_FFFF);
        load(LW,  9'h008, 32'hA5A5_0008, "t4_sw_dropped");

        // Unsupported widths: store ignored, load returns zero.
        store(3'b011, 9'h008, 32'hFFFF_FFFF);
        load(LW,     9'h008, 32'hA5A5_0008, "t4_st_bu_ignored");
        load(3'b101, 9'h008, 32'h0,         "t4_ld_101_zero");

        // Partial stores: lane2 receives 0x44 and lane3 0x33 from the SH.
        store(LB, 9'h010, 32'h0000_0011);
        store(LB, 9'h011, 32'h0000_0022);
        store(LH, 9'h012, 32'h0000_3344);
        load(LW,  9'h010, 32'h3344_2211, "t5_partial");
        idle();
        check("t5_hold", bus.rdata, 32'h3344_2211);
        load(LH,  9'h012, 32'h0000_3344, "t5_lh_hi");

        // Same-edge write and read: read-first.
        cycle(1'b1, 1'b1, LW, 9'h004, 32'hDEAD_BEEF);
        check("t6_read_first", bus.rdata, 32'hA5A5_0004);
        load(LW, 9'h004, 32'hDEAD_BEEF, "t6_after_write");

        // Reset with a store and a load pending: both discarded.
        @(negedge clk);
        rst           = 1'b1;
        bus.we        = 1'b1;
        bus.re        = 1'b1;
        bus.width_sel = LW;
        bus.addr      = 9'h004;
        bus.wdata     = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("t6_rst_clear", bus.rdata, 32'h0);
        @(negedge clk);
        rst    = 1'b0;
        bus.we = 1'b0;
        bus.re = 1'b0;
        idle();
        check("t6_rst_hold", bus.rdata, 32'h0);
        load(LW, 9'h004, 32'hDEAD_BEEF, "t6_no_write_in_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
